// File: rtl/tcb_lib_width_splitter.sv
// TCB bus-width down-converter: splits a wide upstream transfer into aligned
// narrow downstream beats, then reassembles read data and merges the error
// status so the upstream side sees the same fixed response delay.
module tcb_lib_width_splitter #(
    parameter int unsigned DLY     = 1,
    parameter int unsigned ABW     = 32,
    parameter int unsigned SUB_DBW = 32,
    parameter int unsigned MAN_DBW = 8,
    parameter int unsigned SZW     = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    // upstream (wide) side
    input  logic                 sub_vld,
    output logic                 sub_rdy,
    input  logic                 sub_wen,
    input  logic [ABW-1:0]       sub_adr,
    input  logic [SZW-1:0]       sub_siz,
    input  logic [SUB_DBW/8-1:0] sub_byt,
    input  logic [SUB_DBW-1:0]   sub_wdt,
    output logic [SUB_DBW-1:0]   sub_rdt,
    output logic                 sub_err,
    // downstream (narrow) side
    output logic                 man_vld,
    input  logic                 man_rdy,
    output logic                 man_wen,
    output logic [ABW-1:0]       man_adr,
    output logic [SZW-1:0]       man_siz,
    output logic [MAN_DBW/8-1:0] man_byt,
    output logic [MAN_DBW-1:0]   man_wdt,
    input  logic [MAN_DBW-1:0]   man_rdt,
    input  logic                 man_err,
    // misaligned request flag
    output logic                 mal
);

    localparam int unsigned SB  = SUB_DBW / 8;
    localparam int unsigned MB  = MAN_DBW / 8;
    localparam int unsigned N   = SB / MB;
    localparam int unsigned SW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MSZ = $clog2(MB);
    localparam int unsigned SBL = $clog2(SB);

    // one response-tracking entry per cycle
    typedef struct packed {
        logic          vld;
        logic [SW-1:0] sl;
        logic          fst;
        logic          lst;
        logic          lerr;
    } meta_t;

    logic [SW-1:0]      cnt;
    logic [31:0]        siz32;
    logic [31:0]        last_k;
    logic [ABW-1:0]     amask;
    logic               mis;
    logic               lst;
    logic [SW-1:0]      sl;
    logic               man_hs;
    logic               sub_hs;
    meta_t              cur;
    meta_t              rsp;
    logic [SUB_DBW-1:0] asm_q;
    logic               acc_q;
    logic [SUB_DBW-1:0] asm_src;
    logic               acc_src;
    logic [SUB_DBW-1:0] merged;

    // request decode: alignment, beat count and current slice
    always_comb begin
        siz32  = 32'(sub_siz);
        amask  = ABW'((32'd1 << siz32) - 32'd1);
        mis    = (siz32 > SBL) || ((sub_adr & amask) != '0);
        last_k = (siz32 > MSZ) ? ((32'd1 << (siz32 - MSZ)) - 32'd1) : 32'd0;
        lst    = (32'(cnt) == last_k);
        sl     = SW'((sub_adr & ABW'(SB - 1)) >> MSZ) + cnt;
    end

    assign mal     = sub_vld & mis;
    assign man_vld = sub_vld & ~mis;
    assign sub_rdy = mis | (man_rdy & lst);
    assign man_wen = sub_wen;
    assign man_adr = sub_adr + (ABW'(cnt) << MSZ);
    assign man_siz = (siz32 > MSZ) ? SZW'(MSZ) : sub_siz;
    assign man_wdt = sub_wdt[sl*MAN_DBW +: MAN_DBW];
    assign man_byt = sub_byt[sl*MB +: MB];

    assign man_hs = man_vld & man_rdy;
    assign sub_hs = sub_vld & sub_rdy;

    // beat counter: advances per downstream beat, clears on upstream handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (sub_hs) begin
            cnt <= '0;
        end else if (man_hs && !lst) begin
            cnt <= cnt + 1'b1;
        end
    end

    // metadata for the entry issued this cycle
    always_comb begin
        cur.vld  = man_hs | (sub_vld & mis);
        cur.sl   = sl;
        cur.fst  = mis | (cnt == '0);
        cur.lst  = mis | lst;
        cur.lerr = mis;
    end

    generate
        if (DLY == 0) begin : g_bypass
            assign rsp = cur;
        end else begin : g_pipe
            meta_t pipe [DLY];

            // delay line aligning each entry with its downstream response
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int unsigned i = 0; i < DLY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= cur;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign rsp = pipe[DLY-1];
        end
    endgenerate

    // response merge: first beat starts from a clean assembly, last beat emits
    always_comb begin
        asm_src = rsp.fst ? '0 : asm_q;
        acc_src = rsp.fst ? 1'b0 : acc_q;
        merged  = asm_src;
        merged[rsp.sl*MAN_DBW +: MAN_DBW] = man_rdt;
        sub_rdt = '0;
        sub_err = 1'b0;
        if (rsp.vld && rsp.lst) begin
            if (rsp.lerr) begin
                sub_err = 1'b1;
            end else begin
                sub_rdt = merged;
                sub_err = acc_src | man_err;
            end
        end
    end

    // assembly register and error accumulator across beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
            acc_q <= 1'b0;
        end else if (rsp.vld && !rsp.lerr) begin
            asm_q <= merged;
            acc_q <= acc_src | man_err;
        end
    end

endmodule
